// File: rtl/uart_rx_core_if.sv
// Consumer-side bundle of the UART receive core: received byte, status flags and read-clear.
interface uart_rx_core_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       overrun;
  logic       frame_err;
  logic       busy;
  logic       rx_clr;

  modport master (
    output rx_data, rx_rdy, overrun, frame_err, busy,
    input  rx_clr
  );

  modport slave (
    input  rx_data, rx_rdy, overrun, frame_err, busy,
    output rx_clr
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: 16x oversampling, mid-bit sampling, one-entry byte buffer with
// ready/overrun/framing-error status and a break-hold state for a line stuck low.
module uart_rx_core #(
  parameter int unsigned DIV_00 = 651,
  parameter int unsigned DIV_01 = 326,
  parameter int unsigned DIV_10 = 163,
  parameter int unsigned DIV_11 = 81
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  input  logic [1:0]       br_cfg,
  uart_rx_core_if.master   rx
);

  localparam int unsigned DIV_A   = (DIV_00 > DIV_01) ? DIV_00 : DIV_01;
  localparam int unsigned DIV_B   = (DIV_10 > DIV_11) ? DIV_10 : DIV_11;
  localparam int unsigned DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
  localparam int unsigned CNT_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned SAMP_W  = 4;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                sync1;
  logic                rs;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    div_q;
  logic [CNT_W-1:0]    div_sel;
  logic [SAMP_W-1:0]   samp;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          shift;
  logic                tick;
  logic                start_frame;
  logic                start_ok;
  logic                sample_bit;
  logic                done;
  logic                ferr_set;

  // Baud divisor selection; only captured when a frame begins.
  always_comb begin
    div_sel = CNT_W'(DIV_00);
    case (br_cfg)
      2'b00:   div_sel = CNT_W'(DIV_00);
      2'b01:   div_sel = CNT_W'(DIV_01);
      2'b10:   div_sel = CNT_W'(DIV_10);
      default: div_sel = CNT_W'(DIV_11);
    endcase
  end

  assign tick = (state != IDLE) && (cnt == (div_q - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rs    <= 1'b1;
    end else begin
      sync1 <= rxd;
      rs    <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    start_ok    = 1'b0;
    sample_bit  = 1'b0;
    done        = 1'b0;
    ferr_set    = 1'b0;
    case (state)
      IDLE: begin
        if (!rs) begin
          state_nxt   = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        // Mid start bit: a high line here means the falling edge was a glitch.
        if (tick && samp == SAMP_W'(7)) begin
          if (rs) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            start_ok  = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick && samp == SAMP_W'(15)) begin
          sample_bit = 1'b1;
          if (idx == IDX_W'(7)) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick && samp == SAMP_W'(15)) begin
          if (rs) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = BRK;
          end
        end
      end
      BRK: begin
        if (rs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= CNT_W'(DIV_00);
      samp  <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      if (start_frame) begin
        cnt   <= '0;
        samp  <= '0;
        div_q <= div_sel;
      end else if (state != IDLE) begin
        cnt <= tick ? '0 : cnt + CNT_W'(1);
        if (tick) samp <= start_ok ? '0 : samp + SAMP_W'(1);
      end
      if (start_ok) idx <= '0;
      if (sample_bit) begin
        shift[idx] <= rs;
        idx        <= idx + IDX_W'(1);
      end
    end
  end

  // Byte buffer and status; a completing byte takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx.rx_data   <= 8'h00;
      rx.rx_rdy    <= 1'b0;
      rx.overrun   <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.busy      <= 1'b0;
    end else begin
      rx.busy <= (state_nxt != IDLE);
      if (done) begin
        rx.rx_data <= shift;
        rx.rx_rdy  <= 1'b1;
        rx.overrun <= rx.rx_clr ? 1'b0 : rx.rx_rdy;
        if (rx.rx_clr) rx.frame_err <= 1'b0;
      end else if (ferr_set) begin
        rx.frame_err <= 1'b1;
        if (rx.rx_clr) begin
          rx.rx_rdy  <= 1'b0;
          rx.overrun <= 1'b0;
        end
      end else if (rx.rx_clr) begin
        rx.rx_rdy    <= 1'b0;
        rx.overrun   <= 1'b0;
        rx.frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus random frames against a
// frame-level model of the receive buffer and its status flags.
module tb_uart_rx_core;

  localparam int unsigned BIT_CLK  = 64;
  localparam int unsigned DONE_CLK = 611;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [1:0] br_cfg;

  uart_rx_core_if rx ();

  uart_rx_core #(.DIV_01(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .br_cfg (br_cfg),
    .rx     (rx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_ovr;
  logic       m_fe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
  endtask

  task automatic model_clr();
    m_rdy = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic clr_same);
    if (stop_ok) begin
      if (clr_same) begin
        m_ovr = 1'b0;
        m_fe  = 1'b0;
      end else if (m_rdy) begin
        m_ovr = 1'b1;
      end
      m_data = b;
      m_rdy  = 1'b1;
    end else begin
      m_fe = 1'b1;
      if (clr_same) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    check({tag, ".rx_data"},   32'(rx.rx_data),   32'(m_data));
    check({tag, ".rx_rdy"},    32'(rx.rx_rdy),    32'(m_rdy));
    check({tag, ".overrun"},   32'(rx.overrun),   32'(m_ovr));
    check({tag, ".frame_err"}, 32'(rx.frame_err), 32'(m_fe));
    check({tag, ".busy"},      32'(rx.busy),      32'(0));
  endtask

  // Stop bit lasts stop_len clocks (longer than one bit models a held-low line).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (BIT_CLK) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (BIT_CLK) @(posedge clk);
    end
    #1 rxd = stop;
    repeat (stop_len) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (24) @(posedge clk);
  endtask

  task automatic clr_at_done();
    @(posedge clk);
    repeat (DONE_CLK - 1) @(posedge clk);
    #1 rx.rx_clr = 1'b1;
    @(posedge clk); #1 rx.rx_clr = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 rx.rx_clr = 1'b1;
    @(posedge clk); #1 rx.rx_clr = 1'b0;
    model_clr();
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    int         mode;

    rst = 1'b1; rxd = 1'b1; br_cfg = 2'b01; rx.rx_clr = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset");

    send_frame(8'hA5, 1'b1, BIT_CLK);
    model_frame(8'hA5, 1'b1, 1'b0);
    check_all("t1_a5");
    pulse_clr();
    check_all("t1_clr");

    send_frame(8'h3C, 1'b1, BIT_CLK);
    model_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, BIT_CLK);
    model_frame(8'hC3, 1'b1, 1'b0);
    check_all("t2_ovr");
    pulse_clr();
    check_all("t2_clr");

    fork
      send_frame(8'h55, 1'b0, 200);
      begin
        @(posedge clk);
        repeat (9 * BIT_CLK + 150) @(posedge clk);
        @(negedge clk);
        check("t3_brk_busy", 32'(rx.busy), 32'(1));
        check("t3_brk_fe", 32'(rx.frame_err), 32'(1));
        check("t3_brk_rdy", 32'(rx.rx_rdy), 32'(0));
      end
    join
    model_frame(8'h55, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    check_all("t3_after");
    pulse_clr();

    @(posedge clk); #1 rxd = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_busy_up", 32'(rx.busy), 32'(1));
    repeat (10) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (20) @(posedge clk);
    check_all("t4_glitch");

    fork
      send_frame(8'hFF, 1'b1, BIT_CLK);
      begin
        @(posedge clk);
        repeat (5 * BIT_CLK + 32) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    model_reset();
    check_all("t5_aborted");
    send_frame(8'h81, 1'b1, BIT_CLK);
    model_frame(8'h81, 1'b1, 1'b0);
    check_all("t5_81");

    send_frame(8'h77, 1'b1, BIT_CLK);
    model_frame(8'h77, 1'b1, 1'b0);
    fork
      send_frame(8'h12, 1'b1, BIT_CLK);
      clr_at_done();
    join
    model_frame(8'h12, 1'b1, 1'b1);
    check_all("t6_race");

    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      ok   = ($urandom_range(0, 5) != 0);
      mode = int'($urandom_range(0, 2));
      if (mode == 1) pulse_clr();
      fork
        send_frame(b, ok, BIT_CLK);
        if (mode == 2) clr_at_done();
        begin
          repeat (200) @(posedge clk);
          #1 br_cfg = 2'($urandom);
          repeat (300) @(posedge clk);
          #1 br_cfg = 2'b01;
        end
      join
      model_frame(b, ok, mode == 2);
      check_all($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
